// File: rtl/inst_bus_pkg.sv
// Shared definitions for the instruction bus arbiter: width defaults,
// arbitration FSM states and the two-way requester index.
package inst_bus_pkg;

  localparam int INST_W_DEF = 12;
  localparam int DEV_N_DEF  = 8;

  typedef enum logic [1:0] {
    ARB  = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  typedef logic req_idx_t;

  localparam req_idx_t REQ0 = 1'b0;
  localparam req_idx_t REQ1 = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin selector: on a tie the requester that was not
// granted most recently wins.
module rr_pick2
  import inst_bus_pkg::*;
(
  input  logic [1:0] elig,
  input  req_idx_t   last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (elig)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last == REQ1) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/inst_arbiter.sv
// Two-requester instruction bus arbiter with registered one-cycle issue.
// Define INST_ARBITER_LOCK_EN to build the ownership lock (OWN0/OWN1 + timeout).
module inst_arbiter
  import inst_bus_pkg::*;
#(
  parameter int INST_W  = INST_W_DEF,
  parameter int DEV_N   = DEV_N_DEF,
  parameter int LOCK_TO = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [INST_W-1:0] req0_inst,
  input  logic [INST_W-1:0] req1_inst,
  input  logic [DEV_N-1:0]  req0_wen,
  input  logic [DEV_N-1:0]  req1_wen,
  input  logic              req0_valid,
  input  logic              req1_valid,
  input  logic              req0_lock,
  input  logic              req1_lock,
  output logic              req0_ready,
  output logic              req1_ready,
  input  logic [DEV_N-1:0]  dev_busy,
  output logic [INST_W-1:0] inst,
  output logic [DEV_N-1:0]  inst_wen
);

  logic [1:0][DEV_N-1:0] wen_arr;
  logic [1:0]            valid_arr;
  logic [1:0]            elig;
  logic [1:0]            allow;
  logic [1:0]            grant;
  logic                  xfer;
  req_idx_t              xfer_idx;
  req_idx_t              last_reg;
  arb_state_t            state;
  logic [INST_W-1:0]     inst_reg;
  logic [DEV_N-1:0]      inst_wen_reg;

  assign wen_arr   = {req1_wen, req0_wen};
  assign valid_arr = {req1_valid, req0_valid};

  // A requester aimed at any busy device sits out without blocking the other.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_elig
      assign elig[gi] = valid_arr[gi] && ((wen_arr[gi] & dev_busy) == '0);
    end
  endgenerate

  always_comb begin
    allow = 2'b11;
    case (state)
      OWN0:    allow = 2'b01;
      OWN1:    allow = 2'b10;
      default: allow = 2'b11;
    endcase
  end

  rr_pick2 u_pick (
    .elig  (elig & allow & {2{~reset}}),
    .last  (last_reg),
    .grant (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign xfer       = |grant;
  assign xfer_idx   = grant[1] ? REQ1 : REQ0;

  always_ff @(posedge clock) begin
    if (reset) begin
      inst_reg     <= '0;
      inst_wen_reg <= '0;
      last_reg     <= REQ1;
    end else begin
      inst_wen_reg <= '0;
      if (xfer) begin
        inst_reg     <= grant[1] ? req1_inst : req0_inst;
        inst_wen_reg <= grant[1] ? req1_wen : req0_wen;
        last_reg     <= xfer_idx;
      end
    end
  end

  assign inst     = inst_reg;
  assign inst_wen = inst_wen_reg;

`ifdef INST_ARBITER_LOCK_EN
  localparam int TMR_W = $clog2(LOCK_TO + 1);

  arb_state_t       state_reg, state_next;
  logic [TMR_W-1:0] timer_reg, timer_next;
  logic             lock_sel;

  assign lock_sel = grant[1] ? req1_lock : req0_lock;
  assign state    = state_reg;

  // While owned, the allow mask guarantees any transfer comes from the owner.
  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    case (state_reg)
      ARB: begin
        if (xfer && lock_sel) begin
          state_next = grant[1] ? OWN1 : OWN0;
          timer_next = '0;
        end
      end
      OWN0, OWN1: begin
        if (xfer) begin
          timer_next = '0;
          if (!lock_sel) state_next = ARB;
        end else if (timer_reg == TMR_W'(LOCK_TO - 1)) begin
          state_next = ARB;
          timer_next = '0;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      default: begin
        state_next = ARB;
        timer_next = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= ARB;
      timer_reg <= '0;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
    end
  end
`else
  localparam int unused_lock_to = LOCK_TO;
  logic unused_lock;

  assign unused_lock = req0_lock ^ req1_lock;
  assign state       = ARB;
`endif

endmodule

// File: tb/tb_inst_arbiter.sv
// Directed scoreboard bench for inst_arbiter; lock scenarios run only when
// INST_ARBITER_LOCK_EN is defined.
module tb_inst_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [11:0] req0_inst, req1_inst;
  logic [7:0]  req0_wen, req1_wen;
  logic        req0_valid, req1_valid;
  logic        req0_lock, req1_lock;
  logic        req0_ready, req1_ready;
  logic [7:0]  dev_busy;
  logic [11:0] inst;
  logic [7:0]  inst_wen;

  typedef struct packed {
    logic [11:0] inst;
    logic [7:0]  wen;
  } exp_t;

  exp_t        sb[$];
  logic [11:0] exp_inst = '0;
  int          n_assert = 0;
  int          n_fail   = 0;

  always #5 clock = ~clock;

  inst_arbiter #(.INST_W(12), .DEV_N(8), .LOCK_TO(16)) dut (
    .clock      (clock),
    .reset      (reset),
    .req0_inst  (req0_inst),
    .req1_inst  (req1_inst),
    .req0_wen   (req0_wen),
    .req1_wen   (req1_wen),
    .req0_valid (req0_valid),
    .req1_valid (req1_valid),
    .req0_lock  (req0_lock),
    .req1_lock  (req1_lock),
    .req0_ready (req0_ready),
    .req1_ready (req1_ready),
    .dev_busy   (dev_busy),
    .inst       (inst),
    .inst_wen   (inst_wen)
  );

  // One cycle: check the output of the previous cycle, drive new inputs,
  // check the combinational grant, and queue the output expected next cycle.
  task automatic step(input string tag, input logic rst,
                      input logic v0, input logic [11:0] i0, input logic [7:0] w0, input logic l0,
                      input logic v1, input logic [11:0] i1, input logic [7:0] w1, input logic l1,
                      input logic [7:0] busy, input logic er0, input logic er1);
    exp_t e;
    @(negedge clock);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_assert++;
      assert (inst === e.inst) else begin
        n_fail++;
        $error("FAIL %s inst: got %h expected %h", tag, inst, e.inst);
      end
      n_assert++;
      assert (inst_wen === e.wen) else begin
        n_fail++;
        $error("FAIL %s inst_wen: got %h expected %h", tag, inst_wen, e.wen);
      end
    end
    reset = rst;
    req0_valid = v0; req0_inst = i0; req0_wen = w0; req0_lock = l0;
    req1_valid = v1; req1_inst = i1; req1_wen = w1; req1_lock = l1;
    dev_busy = busy;
    #1;
    n_assert++;
    assert (req0_ready === er0) else begin
      n_fail++;
      $error("FAIL %s req0_ready: got %b expected %b", tag, req0_ready, er0);
    end
    n_assert++;
    assert (req1_ready === er1) else begin
      n_fail++;
      $error("FAIL %s req1_ready: got %b expected %b", tag, req1_ready, er1);
    end
    if (rst) begin
      exp_inst = '0;
      e = '{inst: 12'h000, wen: 8'h00};
    end else if (er0) begin
      exp_inst = i0;
      e = '{inst: i0, wen: w0};
    end else if (er1) begin
      exp_inst = i1;
      e = '{inst: i1, wen: w1};
    end else begin
      e = '{inst: exp_inst, wen: 8'h00};
    end
    sb.push_back(e);
    $display("step %-10s rst=%b v0=%b v1=%b busy=%h -> ready0=%b ready1=%b inst=%h wen=%h",
             tag, rst, v0, v1, busy, req0_ready, req1_ready, inst, inst_wen);
  endtask

  initial begin
    reset = 1'b1;
    req0_valid = 0; req1_valid = 0; req0_lock = 0; req1_lock = 0;
    req0_inst = '0; req1_inst = '0; req0_wen = '0; req1_wen = '0; dev_busy = '0;

    // Reset: ready stays low even with a valid request
    step("rst_a",  1, 1, 12'h123, 8'h01, 0, 0, 12'h000, 8'h00, 0, 8'h00, 0, 0);
    step("rst_b",  1, 0, 12'h000, 8'h00, 0, 0, 12'h000, 8'h00, 0, 8'h00, 0, 0);
    // Single requester, one-cycle latency, one-cycle pulse
    step("single", 0, 1, 12'h123, 8'h01, 0, 0, 12'h000, 8'h00, 0, 8'h00, 1, 0);
    step("idle1",  0, 0, 12'h000, 8'h00, 0, 0, 12'h000, 8'h00, 0, 8'h00, 0, 0);
    step("idle2",  0, 0, 12'h000, 8'h00, 0, 0, 12'h000, 8'h00, 0, 8'h00, 0, 0);
    // Round-robin after reset: 0,1,0,1
    step("rst_c",  1, 0, 12'h000, 8'h00, 0, 0, 12'h000, 8'h00, 0, 8'h00, 0, 0);
    step("rr0",    0, 1, 12'h0A1, 8'h01, 0, 1, 12'h0B2, 8'h02, 0, 8'h00, 1, 0);
    step("rr1",    0, 1, 12'h0A1, 8'h01, 0, 1, 12'h0B2, 8'h02, 0, 8'h00, 0, 1);
    step("rr2",    0, 1, 12'h0A1, 8'h01, 0, 1, 12'h0B2, 8'h02, 0, 8'h00, 1, 0);
    step("rr3",    0, 1, 12'h0A1, 8'h01, 0, 1, 12'h0B2, 8'h02, 0, 8'h00, 0, 1);
    // Busy device blocks only its requester
    step("busy_a", 0, 1, 12'h0C3, 8'h02, 0, 1, 12'h0D4, 8'h01, 0, 8'h02, 0, 1);
    step("busy_b", 0, 1, 12'h0C3, 8'h02, 0, 0, 12'h000, 8'h00, 0, 8'h02, 0, 0);
    step("busy_c", 0, 1, 12'h0C3, 8'h02, 0, 0, 12'h000, 8'h00, 0, 8'h00, 1, 0);
    step("idle3",  0, 0, 12'h000, 8'h00, 0, 0, 12'h000, 8'h00, 0, 8'h00, 0, 0);
    // wen all-zero is a no-op that is always eligible
    step("noop",   0, 0, 12'h000, 8'h00, 0, 1, 12'h0E5, 8'h00, 0, 8'hFF, 0, 1);
    // Multi-hot wen: blocked by any busy target, then broadcast
    step("bc_blk", 0, 1, 12'h0F6, 8'h81, 0, 0, 12'h000, 8'h00, 0, 8'h80, 0, 0);
    step("bc_go",  0, 1, 12'h0F6, 8'h81, 0, 1, 12'h107, 8'h06, 0, 8'h00, 1, 0);
    // Busy rising after the grant does not cancel the issued broadcast
    step("late_b", 0, 0, 12'h000, 8'h00, 0, 1, 12'h107, 8'h06, 0, 8'h81, 0, 1);
    step("idle4",  0, 0, 12'h000, 8'h00, 0, 0, 12'h000, 8'h00, 0, 8'h00, 0, 0);

`ifdef INST_ARBITER_LOCK_EN
    step("l_rst",  1, 0, 12'h000, 8'h00, 0, 0, 12'h000, 8'h00, 0, 8'h00, 0, 0);
    step("lock0",  0, 1, 12'h111, 8'h01, 1, 0, 12'h000, 8'h00, 0, 8'h00, 1, 0);
    for (int k = 0; k < 10; k++)
      step("own_blk", 0, 0, 12'h000, 8'h00, 0, 1, 12'h2B2, 8'h02, 0, 8'h00, 0, 0);
    step("unlock", 0, 1, 12'h222, 8'h01, 0, 1, 12'h2B2, 8'h02, 0, 8'h00, 1, 0);
    step("after",  0, 0, 12'h000, 8'h00, 0, 1, 12'h2B2, 8'h02, 0, 8'h00, 0, 1);
    // Timeout: 16 idle owner cycles, req1 granted on the 17th
    step("lock_t", 0, 1, 12'h333, 8'h01, 1, 1, 12'h3B3, 8'h02, 0, 8'h00, 1, 0);
    for (int k = 0; k < 16; k++)
      step("to_wait", 0, 0, 12'h000, 8'h00, 0, 1, 12'h3B3, 8'h02, 0, 8'h00, 0, 0);
    step("to_free", 0, 0, 12'h000, 8'h00, 0, 1, 12'h3B3, 8'h02, 0, 8'h00, 0, 1);
    // Reset while owned with an issue in flight
    step("lock_r", 0, 1, 12'h444, 8'h01, 1, 0, 12'h000, 8'h00, 0, 8'h00, 1, 0);
    step("rst_own", 1, 1, 12'h555, 8'h01, 1, 0, 12'h000, 8'h00, 0, 8'h00, 0, 0);
    step("post_r", 0, 0, 12'h000, 8'h00, 0, 1, 12'h4B4, 8'h02, 0, 8'h00, 0, 1);
    step("idle5",  0, 0, 12'h000, 8'h00, 0, 0, 12'h000, 8'h00, 0, 8'h00, 0, 0);
`endif

    // Final drain so the last queued output is compared
    step("drain",  0, 0, 12'h000, 8'h00, 0, 0, 12'h000, 8'h00, 0, 8'h00, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_arbiter.md
INST_ARBITER -- requirements
Module: inst_arbiter

Interface
REQ-001 Parameter INST_W, default 12, instruction word width.
REQ-002 Parameter DEV_N, default 8, number of device write-enable lines (one-hot device select).
REQ-003 Parameter LOCK_TO, default 16, lock timeout in idle owner cycles (only used with lock compiled in).
REQ-004 clock  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req0_inst / req1_inst  input  INST_W  instruction offered by requester 0 / 1.
REQ-007 req0_wen / req1_wen  input  DEV_N  target device enables for the offered instruction.
REQ-008 req0_valid / req1_valid  input  1  requester has an instruction pending.
REQ-009 req0_lock / req1_lock  input  1  keep ownership after this transfer (lock build only).
REQ-010 req0_ready / req1_ready  output  1  combinational accept; transfer occurs when valid and ready are both high.
REQ-011 dev_busy  input  DEV_N  device n cannot accept an instruction this cycle (e.g. stopwatch counter not ready).
REQ-012 inst  output  INST_W  registered instruction to the device bus.
REQ-013 inst_wen  output  DEV_N  registered one-cycle device enables, paired with inst.

Function
REQ-014 Eligibility: requester eligible when valid and (wen AND dev_busy) is all-zero.
REQ-015 Exactly one requester shall be granted per cycle, or none; ready is high only for the granted requester.
REQ-016 Only one eligible: that requester is granted.
REQ-017 Both eligible: the requester not granted most recently wins (round-robin pointer `last`, updated on every transfer).
REQ-018 Ineligible requester blocked on a busy device shall not block the other requester.
REQ-019 Latency: instruction accepted in cycle t appears on inst/inst_wen in cycle t+1, for exactly one cycle.
REQ-020 No transfer in a cycle: inst_wen = 0 next cycle; inst holds its previous value.
REQ-021 wen all-zero: accepted normally, issues inst with inst_wen = 0 (no-op); multi-hot wen passes through unchanged (broadcast); it is eligible only if all targeted devices are free.
REQ-022 dev_busy is sampled in the grant cycle only; a device going busy at t+1 does not cancel an issued instruction.
REQ-023 FSM states: ARB (free arbitration), OWN0, OWN1 (locked to requester 0/1); without the lock build, only ARB exists.

Reset
REQ-024 On reset: inst = 0, inst_wen = 0, state = ARB, `last` = requester 1 (requester 0 wins first tie), lock timer = 0.
REQ-025 Reset asserted mid-lock or mid-issue: the pending output is discarded and the ownership lock is dropped; no transfer is acknowledged while reset is high (ready = 0).

Configuration
REQ-026 Macro INST_ARBITER_LOCK_EN defined: the lock ports are active and OWN0/OWN1 are implemented.
REQ-027 With the macro defined: a transfer with lock = 1 from requester n enters OWNn; in OWNn only requester n may be granted, regardless of the round-robin pointer.
REQ-028 With the macro defined: OWNn returns to ARB on a transfer from n with lock = 0.
REQ-029 With the macro defined: OWNn also returns to ARB after LOCK_TO consecutive cycles with no transfer from n; a transfer resets the timer.
REQ-030 Macro undefined: the lock inputs are ignored, the state is permanently ARB, and the timer is absent.

Structure
REQ-031 Shared package inst_bus_pkg holds INST_W and DEV_N defaults, the FSM state enum (ARB, OWN0, OWN1), and the requester index type.
REQ-032 Sub-module rr_pick2 (two-way round-robin selector: valid/eligible and last in, grant out) is the natural split; the FSM and output register stay in inst_arbiter.

Verification
REQ-033 Only req0 valid, inst=0x123, wen=0x01, dev_busy=0 -> req0_ready=1 at t; inst=0x123, inst_wen=0x01 at t+1; inst_wen=0 at t+2.
REQ-034 Both valid for 4 cycles (req0 wen=0x01, req1 wen=0x02), no busy -> grant order 0,1,0,1 after reset; inst_wen 0x01,0x02,0x01,0x02.
REQ-035 req0 wen=0x02 with dev_busy=0x02, req1 wen=0x01 -> req1 granted immediately; req0 granted in the first cycle dev_busy[1] drops.
REQ-036 Lock build: req0 transfers with lock=1, then req1 valid for 10 cycles while req0 is idle -> req1_ready=0 throughout; req0 transfer with lock=0 -> req1 granted the next cycle.
REQ-037 Lock build: req0 locks, then stays idle for 16 cycles while req1 is valid -> req1 granted in cycle 17 after the lock transfer, not earlier.
REQ-038 Reset asserted while OWN0, with an instruction issued the same cycle -> next cycle inst=0, inst_wen=0, state ARB; req0 wins the first post-reset tie.
